// File: rtl/iob_soc_versat_ext_mem_pkg.sv
// Shared constants, types and helpers for the Versat external memory model.
package iob_soc_versat_ext_mem_pkg;

  localparam int WRITE_MODE_OLD = 0;
  localparam int WRITE_MODE_NEW = 1;
  localparam int COLL_CNT_W     = 16;
  localparam int BANK_SEL_W     = 3;

  // Debug read tracking: which bank the in-flight read belongs to.
  typedef struct packed {
    logic                  vld;
    logic [BANK_SEL_W-1:0] bank;
  } dbg_stage_t;

  // Bank index sits directly above the word address in the debug address.
  function automatic logic [BANK_SEL_W-1:0] bank_sel(input logic [31:0] dbg_addr,
                                                      input int unsigned addr_w);
    logic [31:0] shifted;
    shifted = dbg_addr >> addr_w;
    return shifted[BANK_SEL_W-1:0];
  endfunction

endpackage

// File: rtl/iob_ext_dp_bank.sv
// One true dual-port bank: byte-masked writes, latency-configurable reads,
// cross-port read-during-write bypass and a same-address collision pulse.
module iob_ext_dp_bank
  import iob_soc_versat_ext_mem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_cke,
  input  logic [1:0]                 i_en,
  input  logic [1:0]                 i_we,
  input  logic [2*ADDR_W-1:0]        i_addr,
  input  logic [2*DATA_W-1:0]        i_wdata,
  input  logic [2*(DATA_W/8)-1:0]    i_wstrb,
  input  logic                       i_p1_dbg,
  output logic [2*DATA_W-1:0]        o_rdata,
  output logic [DATA_W-1:0]          o_p1_data,
  output logic                       o_collision
);

  localparam int NB = DATA_W / 8;

  typedef struct packed {
    logic              vld;
    logic              dbg;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic [ADDR_W-1:0] w_addr  [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic [NB-1:0]     w_wstrb [2];

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_d,
                                                input logic [DATA_W-1:0] new_d,
                                                input logic [NB-1:0]     strb);
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int i = 0; i < NB; i++) begin
      if (strb[i]) res[8*i +: 8] = new_d[8*i +: 8];
    end
    return res;
  endfunction

  // Unpack the flattened per-port buses.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_addr[p]  = i_addr[p*ADDR_W +: ADDR_W];
      w_wdata[p] = i_wdata[p*DATA_W +: DATA_W];
      w_wstrb[p] = i_wstrb[p*NB +: NB];
    end
  end

  // Memory write; port 0 is applied last so it wins a same-address double write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_cke) begin
      for (int p = 1; p >= 0; p--) begin
        if (i_en[p] && i_we[p]) begin
          for (int i = 0; i < NB; i++) begin
            if (w_wstrb[p][i]) r_mem[w_addr[p]][8*i +: 8] <= w_wdata[p][8*i +: 8];
          end
        end
      end
    end
  end

  assign o_collision = i_en[0] & i_en[1] & (w_addr[0] == w_addr[1]) & (i_we[0] | i_we[1]);

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int OTH = 1 - p;

    stage_t            w_in;
    stage_t            w_last;
    logic [DATA_W-1:0] r_rdata;

    // Read sample with optional forwarding of the other port's same-cycle write.
    always_comb begin
      w_in.vld  = i_en[p] & ~i_we[p];
      w_in.dbg  = (p == 1) & i_p1_dbg;
      w_in.data = r_mem[w_addr[p]];
      if (WRITE_MODE == WRITE_MODE_NEW && i_en[OTH] && i_we[OTH] &&
          (w_addr[OTH] == w_addr[p])) begin
        w_in.data = f_merge(r_mem[w_addr[p]], w_wdata[OTH], w_wstrb[OTH]);
      end
    end

    if (RD_LAT == 1) begin : g_direct
      assign w_last = w_in;
    end else begin : g_pipe
      stage_t r_pipe [RD_LAT-1];

      // Delay line for the first RD_LAT-1 cycles; reset discards in-flight reads.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int k = 0; k < RD_LAT-1; k++) r_pipe[k] <= '0;
        end else if (i_cke) begin
          r_pipe[0] <= w_in;
          for (int k = 1; k < RD_LAT-1; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end

      assign w_last = r_pipe[RD_LAT-2];
    end

    // Versat-visible read data only moves on a completing Versat read.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_rdata <= '0;
      end else if (i_cke && w_last.vld && !w_last.dbg) begin
        r_rdata <= w_last.data;
      end
    end

    assign o_rdata[p*DATA_W +: DATA_W] = r_rdata;
  end

  assign o_p1_data = g_port[1].w_last.data;

endmodule

// File: rtl/iob_soc_versat_ext_mem_model.sv
// Versat external memory model: N_MEM dual-port banks, a debug port sharing
// port 1 of the addressed bank, and collision monitoring across all banks.
module iob_soc_versat_ext_mem_model
  import iob_soc_versat_ext_mem_pkg::*;
#(
  parameter int N_MEM      = 2,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int WRITE_MODE = 0,
  parameter int DBG_ADDR_W = ADDR_W + 3
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        cke_i,
  input  logic [N_MEM*2*ADDR_W-1:0]   ext_dp_addr_i,
  input  logic [N_MEM*2*DATA_W-1:0]   ext_dp_wdata_i,
  input  logic [N_MEM*2-1:0]          ext_dp_enable_i,
  input  logic [N_MEM*2-1:0]          ext_dp_write_i,
  output logic [N_MEM*2*DATA_W-1:0]   ext_dp_rdata_o,
  input  logic                        dbg_valid_i,
  input  logic [DBG_ADDR_W-1:0]       dbg_addr_i,
  input  logic [DATA_W-1:0]           dbg_wdata_i,
  input  logic [DATA_W/8-1:0]         dbg_wstrb_i,
  output logic                        dbg_ready_o,
  output logic [DATA_W-1:0]           dbg_rdata_o,
  output logic                        dbg_rvalid_o,
  output logic                        collision_o,
  output logic [COLL_CNT_W-1:0]       collision_cnt_o
);

  localparam int NB = DATA_W / 8;

  logic [BANK_SEL_W-1:0]     w_dbg_bank;
  logic [ADDR_W-1:0]         w_dbg_word;
  logic                      w_dbg_wr;
  logic                      w_p1_busy;
  logic                      w_dbg_rd_acc;
  logic [N_MEM*DATA_W-1:0]   w_bank_p1_data;
  logic [N_MEM-1:0]          w_coll;
  logic [3:0]                w_coll_sum;
  logic [COLL_CNT_W:0]       w_cnt_next;
  logic [DATA_W-1:0]         w_dbg_sel;
  dbg_stage_t                w_dbg_in;
  dbg_stage_t                w_dbg_last;

  assign w_dbg_bank = bank_sel(32'(dbg_addr_i), ADDR_W);
  assign w_dbg_word = dbg_addr_i[ADDR_W-1:0];
  assign w_dbg_wr   = |dbg_wstrb_i;

  // Port 1 of the targeted bank is busy when Versat uses it; absent banks never are.
  always_comb begin
    w_p1_busy = 1'b0;
    for (int b = 0; b < N_MEM; b++) begin
      if (w_dbg_bank == BANK_SEL_W'(b)) w_p1_busy = ext_dp_enable_i[2*b+1];
    end
  end

  assign dbg_ready_o  = dbg_valid_i & ~w_p1_busy;
  assign w_dbg_rd_acc = dbg_ready_o & ~w_dbg_wr;

  for (genvar b = 0; b < N_MEM; b++) begin : g_bank
    logic                  w_hit;
    logic [1:0]            w_en;
    logic [1:0]            w_we;
    logic [2*ADDR_W-1:0]   w_addr;
    logic [2*DATA_W-1:0]   w_wdata;
    logic [2*NB-1:0]       w_wstrb;

    assign w_hit   = dbg_ready_o & (w_dbg_bank == BANK_SEL_W'(b));
    assign w_en    = {w_hit | ext_dp_enable_i[2*b+1], ext_dp_enable_i[2*b]};
    assign w_we    = {w_hit ? w_dbg_wr : ext_dp_write_i[2*b+1], ext_dp_write_i[2*b]};
    assign w_addr  = {w_hit ? w_dbg_word : ext_dp_addr_i[(2*b+1)*ADDR_W +: ADDR_W],
                      ext_dp_addr_i[2*b*ADDR_W +: ADDR_W]};
    assign w_wdata = {w_hit ? dbg_wdata_i : ext_dp_wdata_i[(2*b+1)*DATA_W +: DATA_W],
                      ext_dp_wdata_i[2*b*DATA_W +: DATA_W]};
    assign w_wstrb = {w_hit ? dbg_wstrb_i : {NB{1'b1}}, {NB{1'b1}}};

    iob_ext_dp_bank #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .RD_LAT     (RD_LAT),
      .WRITE_MODE (WRITE_MODE)
    ) u_bank (
      .i_clk       (clk_i),
      .i_rst       (arst_i),
      .i_cke       (cke_i),
      .i_en        (w_en),
      .i_we        (w_we),
      .i_addr      (w_addr),
      .i_wdata     (w_wdata),
      .i_wstrb     (w_wstrb),
      .i_p1_dbg    (w_hit),
      .o_rdata     (ext_dp_rdata_o[2*b*DATA_W +: 2*DATA_W]),
      .o_p1_data   (w_bank_p1_data[b*DATA_W +: DATA_W]),
      .o_collision (w_coll[b])
    );
  end

  assign w_dbg_in = '{vld: w_dbg_rd_acc, bank: w_dbg_bank};

  if (RD_LAT == 1) begin : g_dbg_direct
    assign w_dbg_last = w_dbg_in;
  end else begin : g_dbg_pipe
    dbg_stage_t r_dbg_pipe [RD_LAT-1];

    // Track debug reads alongside the bank pipelines so the return can be routed.
    always_ff @(posedge clk_i) begin
      if (arst_i) begin
        for (int k = 0; k < RD_LAT-1; k++) r_dbg_pipe[k] <= '0;
      end else if (cke_i) begin
        r_dbg_pipe[0] <= w_dbg_in;
        for (int k = 1; k < RD_LAT-1; k++) r_dbg_pipe[k] <= r_dbg_pipe[k-1];
      end
    end

    assign w_dbg_last = r_dbg_pipe[RD_LAT-2];
  end

  // Reads of a non-existent bank return zero.
  always_comb begin
    w_dbg_sel = '0;
    for (int b = 0; b < N_MEM; b++) begin
      if (w_dbg_last.bank == BANK_SEL_W'(b)) w_dbg_sel = w_bank_p1_data[b*DATA_W +: DATA_W];
    end
  end

  // Debug read return: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else if (cke_i) begin
      dbg_rvalid_o <= w_dbg_last.vld;
      if (w_dbg_last.vld) dbg_rdata_o <= w_dbg_sel;
    end
  end

  always_comb begin
    w_coll_sum = '0;
    for (int b = 0; b < N_MEM; b++) w_coll_sum = w_coll_sum + 4'(w_coll[b]);
  end

  assign w_cnt_next = {1'b0, collision_cnt_o} + (COLL_CNT_W+1)'(w_coll_sum);

  // Sticky flag plus saturating count of colliding banks per cycle.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      collision_o     <= 1'b0;
      collision_cnt_o <= '0;
    end else if (cke_i && (|w_coll)) begin
      collision_o     <= 1'b1;
      collision_cnt_o <= w_cnt_next[COLL_CNT_W] ? {COLL_CNT_W{1'b1}}
                                                : w_cnt_next[COLL_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_iob_soc_versat_ext_mem_model.sv
// Directed bench: two model instances share stimulus; A has RD_LAT=1 and
// old-data read-during-write, B has RD_LAT=3 and new-data read-during-write.
module tb_iob_soc_versat_ext_mem_model;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst;
  logic          cke;
  logic [23:0]   ext_addr;
  logic [127:0]  ext_wdata;
  logic [3:0]    ext_en;
  logic [3:0]    ext_we;
  logic          dbg_valid;
  logic [8:0]    dbg_addr;
  logic [31:0]   dbg_wdata;
  logic [3:0]    dbg_wstrb;

  logic [127:0]  rdata_a, rdata_b;
  logic          ready_a, ready_b;
  logic [31:0]   drd_a, drd_b;
  logic          rv_a, rv_b;
  logic          coll_a, coll_b;
  logic [15:0]   cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iob_soc_versat_ext_mem_model #(
    .N_MEM(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .WRITE_MODE(0)
  ) u_dut_a (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .ext_dp_addr_i(ext_addr), .ext_dp_wdata_i(ext_wdata),
    .ext_dp_enable_i(ext_en), .ext_dp_write_i(ext_we),
    .ext_dp_rdata_o(rdata_a),
    .dbg_valid_i(dbg_valid), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_wstrb_i(dbg_wstrb), .dbg_ready_o(ready_a), .dbg_rdata_o(drd_a),
    .dbg_rvalid_o(rv_a), .collision_o(coll_a), .collision_cnt_o(cnt_a)
  );

  iob_soc_versat_ext_mem_model #(
    .N_MEM(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .WRITE_MODE(1)
  ) u_dut_b (
    .clk_i(clk), .arst_i(arst), .cke_i(cke),
    .ext_dp_addr_i(ext_addr), .ext_dp_wdata_i(ext_wdata),
    .ext_dp_enable_i(ext_en), .ext_dp_write_i(ext_we),
    .ext_dp_rdata_o(rdata_b),
    .dbg_valid_i(dbg_valid), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_wstrb_i(dbg_wstrb), .dbg_ready_o(ready_b), .dbg_rdata_o(drd_b),
    .dbg_rvalid_o(rv_b), .collision_o(coll_b), .collision_cnt_o(cnt_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sl(input logic [127:0] v, input int b, input int p);
    return v[(2*b+p)*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ext_en = '0; ext_we = '0; ext_addr = '0; ext_wdata = '0;
    dbg_valid = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = '0;
  endtask

  task automatic vrd(input int b, input int p, input logic [5:0] a);
    ext_en[2*b+p] = 1'b1;
    ext_we[2*b+p] = 1'b0;
    ext_addr[(2*b+p)*AW +: AW] = a;
  endtask

  task automatic vwr(input int b, input int p, input logic [5:0] a, input logic [31:0] d);
    ext_en[2*b+p] = 1'b1;
    ext_we[2*b+p] = 1'b1;
    ext_addr[(2*b+p)*AW +: AW] = a;
    ext_wdata[(2*b+p)*DW +: DW] = d;
  endtask

  task automatic dreq(input logic [2:0] bank, input logic [5:0] word,
                      input logic [31:0] d, input logic [3:0] strb);
    dbg_valid = 1'b1;
    dbg_addr  = {bank, word};
    dbg_wdata = d;
    dbg_wstrb = strb;
  endtask

  task automatic dwrite(input logic [2:0] bank, input logic [5:0] word,
                        input logic [31:0] d, input logic [3:0] strb);
    idle();
    dreq(bank, word, d, strb);
    tick();
    idle();
  endtask

  initial begin
    idle();
    cke  = 1'b1;
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;

    // reset state
    check("rst_rdata_a", rdata_a, 128'h0);
    check("rst_rdata_b", rdata_b, 128'h0);
    check("rst_rvalid_a", rv_a, 1'b0);
    check("rst_drdata_b", drd_b, 32'h0);
    check("rst_coll_a", coll_a, 1'b0);
    check("rst_cnt_b", cnt_b, 16'h0);

    // 1: debug write then Versat read, bank 1 word 5
    dreq(3'd1, 6'd5, 32'hDEADBEEF, 4'hF);
    #1;
    check("t1_ready_a", ready_a, 1'b1);
    check("t1_ready_b", ready_b, 1'b1);
    tick();
    idle();
    vrd(1, 0, 6'd5);
    tick();
    idle();
    check("t1_rd_a", sl(rdata_a, 1, 0), 32'hDEADBEEF);
    check("t1_rd_b_lat1", sl(rdata_b, 1, 0), 32'h0);
    tick();
    check("t1_rd_b_lat2", sl(rdata_b, 1, 0), 32'h0);
    tick();
    check("t1_rd_b_lat3", sl(rdata_b, 1, 0), 32'hDEADBEEF);

    // 2: preload bank 0 words 0..7, then pipelined back-to-back reads
    for (int i = 0; i < 8; i++) dwrite(3'd0, 6'(i), 32'h100 + i, 4'hF);
    for (int i = 0; i < 8; i++) begin
      idle();
      vrd(0, 0, 6'(i));
      tick();
      check($sformatf("t2_a_%0d", i), sl(rdata_a, 0, 0), 32'h100 + i);
      check($sformatf("t2_b_%0d", i), sl(rdata_b, 0, 0), (i >= 2) ? 32'h100 + i - 2 : 32'h0);
    end
    idle();
    tick();
    check("t2_a_hold", sl(rdata_a, 0, 0), 32'h107);
    check("t2_b_6", sl(rdata_b, 0, 0), 32'h106);
    tick();
    check("t2_b_7", sl(rdata_b, 0, 0), 32'h107);

    // 3: read-during-write collision on bank 0 word 9
    dwrite(3'd0, 6'd9, 32'h11, 4'hF);
    dwrite(3'd1, 6'd11, 32'h50, 4'hF);
    vwr(0, 0, 6'd9, 32'h22);
    vrd(0, 1, 6'd9);
    tick();
    idle();
    check("t3_old_a", sl(rdata_a, 0, 1), 32'h11);
    check("t3_coll_a", coll_a, 1'b1);
    check("t3_cnt_a", cnt_a, 16'd1);
    check("t3_coll_b", coll_b, 1'b1);
    check("t3_cnt_b", cnt_b, 16'd1);
    tick();
    tick();
    check("t3_new_b", sl(rdata_b, 0, 1), 32'h22);
    // two banks colliding in one cycle: double write on bank 0, RDW on bank 1
    vwr(0, 0, 6'd10, 32'h33);
    vwr(0, 1, 6'd10, 32'h44);
    vwr(1, 0, 6'd11, 32'h55);
    vrd(1, 1, 6'd11);
    tick();
    idle();
    check("t3_cnt2_a", cnt_a, 16'd3);
    check("t3_cnt2_b", cnt_b, 16'd3);
    check("t3_old2_a", sl(rdata_a, 1, 1), 32'h50);
    tick();
    tick();
    check("t3_new2_b", sl(rdata_b, 1, 1), 32'h55);
    vrd(0, 0, 6'd10);
    tick();
    idle();
    check("t3_dw_a", sl(rdata_a, 0, 0), 32'h33);
    tick();
    tick();
    check("t3_dw_b", sl(rdata_b, 0, 0), 32'h33);

    // 4: debug read stalled by Versat port 1 for 4 cycles
    for (int i = 0; i < 4; i++) begin
      idle();
      vrd(0, 1, 6'd0);
      dreq(3'd0, 6'd9, 32'h0, 4'h0);
      #1;
      check($sformatf("t4_stall_a_%0d", i), ready_a, 1'b0);
      check($sformatf("t4_stall_b_%0d", i), ready_b, 1'b0);
      tick();
    end
    idle();
    dreq(3'd0, 6'd9, 32'h0, 4'h0);
    #1;
    check("t4_accept_a", ready_a, 1'b1);
    tick();
    idle();
    check("t4_rv_a", rv_a, 1'b1);
    check("t4_rd_a", drd_a, 32'h22);
    check("t4_rv_b1", rv_b, 1'b0);
    tick();
    check("t4_rv_a_pulse", rv_a, 1'b0);
    check("t4_rv_b2", rv_b, 1'b0);
    tick();
    check("t4_rv_b3", rv_b, 1'b1);
    check("t4_rd_b", drd_b, 32'h22);
    tick();
    check("t4_rv_b_pulse", rv_b, 1'b0);
    check("t4_rd_b_hold", drd_b, 32'h22);
    check("t4_vers_a", sl(rdata_a, 0, 1), 32'h100);
    check("t4_vers_b", sl(rdata_b, 0, 1), 32'h100);

    // 5: byte-masked debug write, then absent-bank accesses
    dwrite(3'd0, 6'd12, 32'h0, 4'hF);
    dwrite(3'd0, 6'd12, 32'hAABBCCDD, 4'b0010);
    dreq(3'd0, 6'd12, 32'h0, 4'h0);
    tick();
    idle();
    check("t5_rv_a", rv_a, 1'b1);
    check("t5_strb_a", drd_a, 32'h0000CC00);
    tick();
    tick();
    check("t5_rv_b", rv_b, 1'b1);
    check("t5_strb_b", drd_b, 32'h0000CC00);
    dwrite(3'd5, 6'd5, 32'hFFFFFFFF, 4'hF);
    dreq(3'd5, 6'd5, 32'h0, 4'h0);
    #1;
    check("t5_oob_ready", ready_a, 1'b1);
    tick();
    idle();
    check("t5_oob_rv_a", rv_a, 1'b1);
    check("t5_oob_rd_a", drd_a, 32'h0);
    tick();
    check("t5_oob_rv_b2", rv_b, 1'b0);
    tick();
    check("t5_oob_rv_b", rv_b, 1'b1);
    check("t5_oob_rd_b", drd_b, 32'h0);

    // 6: reset while reads are in flight
    idle();
    dreq(3'd1, 6'd5, 32'h0, 4'h0);
    tick();
    idle();
    dreq(3'd1, 6'd5, 32'h0, 4'h0);
    vrd(0, 0, 6'd0);
    tick();
    idle();
    dreq(3'd1, 6'd5, 32'h0, 4'h0);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    idle();
    check("t6_rv_a", rv_a, 1'b0);
    check("t6_rdata_a", rdata_a, 128'h0);
    check("t6_cnt_a", cnt_a, 16'h0);
    check("t6_coll_b", coll_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_rv_b_%0d", i), rv_b, 1'b0);
      check($sformatf("t6_drd_b_%0d", i), drd_b, 32'h0);
      check($sformatf("t6_rdata_b_%0d", i), rdata_b, 128'h0);
      tick();
    end
    check("t6_cnt_b", cnt_b, 16'h0);
    vrd(1, 0, 6'd5);
    tick();
    idle();
    check("t6_mem_a", sl(rdata_a, 1, 0), 32'hDEADBEEF);
    tick();
    tick();
    check("t6_mem_b", sl(rdata_b, 1, 0), 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
